bit_order_deser: RTL and testbench

- Serial-to-parallel receiver for the bit-reversal datapath: collects a serial bitstream one bit per handshake and rebuilds WIDTH-bit words.
- Acts as the receiving end for a serializer that emits words LSB-first (reversed order) or MSB-first. The bit order is selectable per word.
- Sits between a serial link and word-wide consumers.
- Valid/ready on both sides, with one word of output buffering plus a stall-capable shift stage.

---
 rtl/bit_order_deser_if.sv | 25 ++
 rtl/bit_order_deser.sv | 104 ++++++++++
 tb/tb_bit_order_deser.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_order_deser_if.sv
// Handshake bundle for the bit-order deserializer.
// Serial side: s_valid/s_ready/s_bit/s_last/msb_first; word side: m_valid/m_ready/m_data/frame_err.
interface bit_order_deser_if #(
    parameter int WIDTH = 5
);
    logic             s_valid;
    logic             s_ready;
    logic             s_bit;
    logic             s_last;
    logic             msb_first;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             frame_err;

    modport slave (
        input  s_valid, s_bit, s_last, msb_first, m_ready,
        output s_ready, m_valid, m_data, frame_err
    );

    modport master (
        output s_valid, s_bit, s_last, msb_first, m_ready,
        input  s_ready, m_valid, m_data, frame_err
    );
endinterface

// File: rtl/bit_order_deser.sv
// Serial-to-parallel receiver rebuilding WIDTH-bit words, LSB- or MSB-first per word.
// Ports: clk, rst_n (async active-low), bus (slave modport: serial in, word out, frame_err).
module bit_order_deser #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_order_deser_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] m_data_q;
    logic             order_q;
    logic             m_valid_q;
    logic             ferr_q;

    logic             acc;
    logic             last_k;
    logic             out_free;
    logic             ord_d;
    logic [CNT_W-1:0] idx;

    assign bus.s_ready   = (state_q != FULL);
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.frame_err = ferr_q;

    assign acc      = bus.s_valid && (state_q != FULL);
    assign last_k   = (cnt_q == LAST);
    // Output register can take a new word if empty or drained this cycle
    assign out_free = !m_valid_q || bus.m_ready;

    // First bit of a word uses the live order pin; later bits the latched one
    always_comb begin
        ord_d        = (cnt_q == '0) ? bus.msb_first : order_q;
        idx          = ord_d ? (LAST - cnt_q) : cnt_q;
        shreg_d      = shreg_q;
        shreg_d[idx] = bus.s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            m_data_q  <= '0;
            order_q   <= 1'b0;
            m_valid_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE, COLLECT: begin
                    if (acc) begin
                        if (cnt_q == '0) begin
                            order_q <= bus.msb_first;
                        end
                        shreg_q <= shreg_d;
                        if (last_k) begin
                            cnt_q <= '0;
                            if (out_free) begin
                                m_data_q  <= shreg_d;
                                m_valid_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                state_q <= FULL;
                            end
                        end else if (bus.s_last) begin
                            cnt_q   <= '0;
                            ferr_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= COLLECT;
                        end
                    end
                end
                FULL: begin
                    // m_valid is always set while FULL; refill it from the held word
                    if (bus.m_ready) begin
                        m_data_q  <= shreg_q;
                        m_valid_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_order_deser.sv
// Bench for bit_order_deser: directed steps plus random traffic against a word-level model.
// Ports: none (top-level bench).
module tb_bit_order_deser;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bit_order_deser_if #(.WIDTH(W)) bus ();

    bit_order_deser #(.WIDTH(W), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bits land at k or W-1-k; one output slot plus one held word
    int           mk = 0;
    logic         mord = 1'b0;
    logic [W-1:0] mword = '0;
    logic         mv = 1'b0;
    logic [W-1:0] md = '0;
    logic         mfull = 1'b0;
    logic [W-1:0] mheld = '0;
    logic         mef = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mk = 0; mv = 1'b0; md = '0; mfull = 1'b0; mef = 1'b0;
            chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
            chk("rst_m_data", 32'(bus.m_data), 32'(0));
            chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
        end else begin
            logic acc;
            int   pos;
            chk("mon_s_ready", 32'(bus.s_ready), 32'(!mfull));
            chk("mon_m_valid", 32'(bus.m_valid), 32'(mv));
            chk("mon_m_data", 32'(bus.m_data), 32'(md));
            chk("mon_frame_err", 32'(bus.frame_err), 32'(mef));
            mef = 1'b0;
            acc = bus.s_valid && !mfull;
            if (mfull) begin
                if (bus.m_ready) begin
                    md = mheld;
                    mfull = 1'b0;
                end
            end else if (mv && bus.m_ready) begin
                mv = 1'b0;
            end
            if (acc) begin
                if (mk == 0) mord = bus.msb_first;
                pos = mord ? (W - 1 - mk) : mk;
                mword[pos] = bus.s_bit;
                if (mk == W - 1) begin
                    mk = 0;
                    if (!mv) begin
                        mv = 1'b1;
                        md = mword;
                    end else begin
                        mfull = 1'b1;
                        mheld = mword;
                    end
                end else if (bus.s_last) begin
                    mk = 0;
                    mef = 1'b1;
                end else begin
                    mk++;
                end
            end
        end
    end

    task automatic send(input logic b, input logic last, input logic ord,
                        input logic mr);
        bus.s_valid = 1'b1;
        bus.s_bit = b;
        bus.s_last = last;
        bus.msb_first = ord;
        bus.m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic mr);
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.m_ready = mr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [4:0] pat;
    logic [W-1:0] ew;

    initial begin
        pat = 5'b01101;
        bus.s_valid = 1'b0;
        bus.s_bit = 1'b0;
        bus.s_last = 1'b0;
        bus.msb_first = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_m_valid", 32'(bus.m_valid), 32'(0));
        chk("reset_m_data", 32'(bus.m_data), 32'(0));
        chk("reset_frame_err", 32'(bus.frame_err), 32'(0));
        rst_n = 1'b1;
        #1;
        chk("reset_s_ready", 32'(bus.s_ready), 32'(1));

        // LSB-first then MSB-first, bits 1,0,1,1,0
        for (int k = 0; k < W; k++) begin
            send(pat[k], 1'b0, 1'b0, 1'b1);
            if (k == W - 2) chk("lsb_not_yet", 32'(bus.m_valid), 32'(0));
        end
        chk("lsb_valid", 32'(bus.m_valid), 32'(1));
        chk("lsb_data", 32'(bus.m_data), 32'h0D);
        for (int k = 0; k < W; k++) send(pat[k], 1'b0, 1'b1, 1'b1);
        chk("msb_data", 32'(bus.m_data), 32'h16);
        idle(1, 1'b1);

        // Backpressure: A held in output, B held in shift stage
        for (int k = 0; k < W; k++) send(pat[k], 1'b0, 1'b0, 1'b0);
        chk("bp_a_data", 32'(bus.m_data), 32'h0D);
        for (int k = 0; k < W; k++) send(pat[k], 1'b0, 1'b1, 1'b0);
        chk("bp_full_s_ready", 32'(bus.s_ready), 32'(0));
        chk("bp_hold_data", 32'(bus.m_data), 32'h0D);
        send(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_still_full", 32'(bus.s_ready), 32'(0));
        idle(1, 1'b1);
        chk("bp_b_data", 32'(bus.m_data), 32'h16);
        chk("bp_b_valid", 32'(bus.m_valid), 32'(1));
        chk("bp_s_ready_back", 32'(bus.s_ready), 32'(1));
        idle(1, 1'b0);
        chk("bp_b_hold", 32'(bus.m_data), 32'h16);
        idle(1, 1'b1);

        // Mid-word order toggle is ignored
        send(1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1, 1'b1);
        chk("toggle_data", 32'(bus.m_data), 32'h03);
        idle(1, 1'b1);

        // Early s_last aborts, next word starts from k=0
        send(1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0, 1'b1);
        chk("abort_ferr", 32'(bus.frame_err), 32'(1));
        chk("abort_no_valid", 32'(bus.m_valid), 32'(0));
        idle(1, 1'b1);
        chk("abort_ferr_pulse", 32'(bus.frame_err), 32'(0));
        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b1);
        chk("after_abort_data", 32'(bus.m_data), 32'h10);
        idle(1, 1'b1);

        // Async reset between edges mid-word
        for (int k = 0; k < 3; k++) send(1'b1, 1'b0, 1'b0, 1'b1);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(bus.m_valid), 32'(0));
        chk("arst_m_data", 32'(bus.m_data), 32'(0));
        chk("arst_s_ready", 32'(bus.s_ready), 32'(1));
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("arst_release_rdy", 32'(bus.s_ready), 32'(1));
        send(1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1, 1'b1);
        chk("arst_next_data", 32'(bus.m_data), 32'h19);
        idle(1, 1'b1);

        // Back-to-back random words, consumer always ready
        for (int w = 0; w < 4; w++) begin
            logic ord;
            logic b;
            ord = 1'($urandom);
            ew = '0;
            for (int k = 0; k < W; k++) begin
                b = 1'($urandom);
                ew[ord ? (W - 1 - k) : k] = b;
                send(b, 1'b0, ord, 1'b1);
                chk("b2b_s_ready", 32'(bus.s_ready), 32'(1));
                chk("b2b_m_valid", 32'(bus.m_valid), 32'(k == W - 1));
            end
            chk("b2b_data", 32'(bus.m_data), 32'(ew));
        end
        idle(1, 1'b1);

        // Random traffic checked by the reference each cycle
        for (int i = 0; i < 400; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_bit = 1'($urandom);
            bus.s_last = ($urandom_range(0, 9) == 0);
            bus.msb_first = 1'($urandom);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        idle(3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
